// File: rtl/pad_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pad_cfg_pkg                                               |
// | Brief    : Shared types for the pad ring configuration controller    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package pad_cfg_pkg;

  // Command opcode, taken from cmd_data[15:14]
  typedef enum logic [1:0] {
    OP_NOP      = 2'b00,
    OP_WRITE    = 2'b01,
    OP_COMMIT   = 2'b10,
    OP_DEFAULTS = 2'b11
  } op_e;

  // Per-pad configuration; bit order matches cmd_data[4:0]
  typedef struct packed {
    logic oe;
    logic cs;
    logic sl;
    logic pu;
    logic pd;
  } pad_cfg_t;

  localparam pad_cfg_t PAD_CFG_RST = '{oe: 1'b0, cs: 1'b0, sl: 1'b0, pu: 1'b0, pd: 1'b0};

  // Controller FSM state
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

endpackage : pad_cfg_pkg
`default_nettype wire

// File: rtl/pad_cfg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pad_cfg_bank                                              |
// | Brief    : Shadow and live per-pad config storage with write, clear  |
// |            and atomic shadow-to-live commit                          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module pad_cfg_bank
  import pad_cfg_pkg::*;
#(
  parameter int NUM_BIDIR = 42,
  parameter int IDX_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  pad_cfg_t             wr_cfg,
  input  logic                 clr_en,
  input  logic [IDX_W-1:0]     clr_idx,
  input  logic                 commit,
  output logic [NUM_BIDIR-1:0] live_oe,
  output logic [NUM_BIDIR-1:0] live_cs,
  output logic [NUM_BIDIR-1:0] live_sl,
  output logic [NUM_BIDIR-1:0] live_pu,
  output logic [NUM_BIDIR-1:0] live_pd
);

  pad_cfg_t shadow_q [NUM_BIDIR];
  pad_cfg_t shadow_d [NUM_BIDIR];
  pad_cfg_t live_q   [NUM_BIDIR];
  pad_cfg_t live_d   [NUM_BIDIR];

  // Next-state for shadow and live; index compare per pad so out-of-range
  // indices can never address a non-existent entry. Commit copies the
  // pre-edge shadow contents.
  always_comb begin
    shadow_d = shadow_q;
    live_d   = live_q;
    for (int i = 0; i < NUM_BIDIR; i++) begin
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        shadow_d[i] = wr_cfg;
      end
      if (clr_en && (clr_idx == IDX_W'(i))) begin
        shadow_d[i] = PAD_CFG_RST;
      end
      if (commit) begin
        live_d[i] = shadow_q[i];
      end
    end
  end

  // Storage registers with synchronous reset to the all-zero config
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BIDIR; i++) begin
        shadow_q[i] <= PAD_CFG_RST;
        live_q[i]   <= PAD_CFG_RST;
      end
    end else begin
      shadow_q <= shadow_d;
      live_q   <= live_d;
    end
  end

  // Fan live config fields out to per-function pad vectors
  generate
    for (genvar g = 0; g < NUM_BIDIR; g++) begin : g_live_out
      assign live_oe[g] = live_q[g].oe;
      assign live_cs[g] = live_q[g].cs;
      assign live_sl[g] = live_q[g].sl;
      assign live_pu[g] = live_q[g].pu;
      assign live_pd[g] = live_q[g].pd;
    end
  endgenerate

endmodule : pad_cfg_bank
`default_nettype wire

// File: rtl/pad_cfg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pad_cfg_ctrl                                              |
// | Brief    : Runtime pad ring configuration controller: command decode,|
// |            DEFAULTS sweep FSM, sticky error and commit counter       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module pad_cfg_ctrl
  import pad_cfg_pkg::*;
#(
  parameter int NUM_BIDIR = 42,
  parameter int IDX_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [15:0]          cmd_data,
  output logic                 err,
  input  logic                 err_clr,
  output logic [7:0]           commit_cnt,
  output logic [NUM_BIDIR-1:0] bidir_oe,
  output logic [NUM_BIDIR-1:0] bidir_cs,
  output logic [NUM_BIDIR-1:0] bidir_sl,
  output logic [NUM_BIDIR-1:0] bidir_ie,
  output logic [NUM_BIDIR-1:0] bidir_pu,
  output logic [NUM_BIDIR-1:0] bidir_pd
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BIDIR - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
  logic             err_q, err_d;
  logic [7:0]       commit_cnt_q, commit_cnt_d;

  op_e              cmd_op;
  logic [5:0]       cmd_idx;
  pad_cfg_t         cmd_cfg;
  logic             accept;
  logic             idx_bad;
  logic             cfg_bad;
  logic             unused_cmd_bits;

  logic             wr_en;
  logic             clr_en;
  logic [IDX_W-1:0] clr_idx;
  logic             commit;

  assign cmd_op          = op_e'(cmd_data[15:14]);
  assign cmd_idx         = cmd_data[13:8];
  assign cmd_cfg         = pad_cfg_t'(cmd_data[4:0]);
  assign unused_cmd_bits = ^cmd_data[7:5];

  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  // Full 6-bit field is range-checked so high index bits never alias a real pad
  assign idx_bad   = ({26'd0, cmd_idx} >= 32'(NUM_BIDIR));
  assign cfg_bad   = cmd_cfg.pu && cmd_cfg.pd;

  // Decode, sweep FSM, error flag and commit counter next-state
  always_comb begin
    state_d      = state_q;
    sweep_idx_d  = sweep_idx_q;
    err_d        = err_q;
    commit_cnt_d = commit_cnt_q;
    wr_en        = 1'b0;
    clr_en       = 1'b0;
    clr_idx      = '0;
    commit       = 1'b0;

    if (err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_WRITE: begin
              if (idx_bad || cfg_bad) begin
                err_d = 1'b1;
              end else begin
                wr_en = 1'b1;
              end
            end
            OP_COMMIT: begin
              commit       = 1'b1;
              commit_cnt_d = commit_cnt_q + 8'd1;
            end
            OP_DEFAULTS: begin
              // Entry edge clears pad 0; a single-pad ring is then done
              clr_en      = 1'b1;
              clr_idx     = '0;
              sweep_idx_d = IDX_W'(1);
              if (NUM_BIDIR > 1) begin
                state_d = ST_SWEEP;
              end
            end
            default: ;
          endcase
        end
      end
      ST_SWEEP: begin
        clr_en      = 1'b1;
        clr_idx     = sweep_idx_q;
        sweep_idx_d = sweep_idx_q + IDX_W'(1);
        if (sweep_idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sweep_idx_q  <= '0;
      err_q        <= 1'b0;
      commit_cnt_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      sweep_idx_q  <= sweep_idx_d;
      err_q        <= err_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  pad_cfg_bank #(
    .NUM_BIDIR (NUM_BIDIR),
    .IDX_W     (IDX_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (IDX_W'(cmd_idx)),
    .wr_cfg  (cmd_cfg),
    .clr_en  (clr_en),
    .clr_idx (clr_idx),
    .commit  (commit),
    .live_oe (bidir_oe),
    .live_cs (bidir_cs),
    .live_sl (bidir_sl),
    .live_pu (bidir_pu),
    .live_pd (bidir_pd)
  );

  // Input enable is always the complement of the live output enable
  assign bidir_ie   = ~bidir_oe;
  assign err        = err_q;
  assign commit_cnt = commit_cnt_q;

endmodule : pad_cfg_ctrl
`default_nettype wire

// File: tb/tb_pad_cfg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pad_cfg_ctrl                                           |
// | Brief    : Directed self-checking bench for pad_cfg_ctrl            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_pad_cfg_ctrl;

  localparam int N = 42;
  localparam logic [N-1:0] ALL1 = {N{1'b1}};
  localparam logic [N-1:0] ALL0 = '0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [15:0]  cmd_data = 16'h0000;
  logic         err;
  logic         err_clr = 1'b0;
  logic [7:0]   commit_cnt;
  logic [N-1:0] bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;

  int checks = 0;
  int errors = 0;

  pad_cfg_ctrl #(.NUM_BIDIR(N), .IDX_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .err        (err),
    .err_clr    (err_clr),
    .commit_cnt (commit_cnt),
    .bidir_oe   (bidir_oe),
    .bidir_cs   (bidir_cs),
    .bidir_sl   (bidir_sl),
    .bidir_ie   (bidir_ie),
    .bidir_pu   (bidir_pu),
    .bidir_pd   (bidir_pd)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command and hold it until accepted (bounded wait)
  task automatic send(input logic [1:0] op, input logic [5:0] idx, input logic [4:0] cfg);
    logic ok;
    int   waits;
    cmd_valid = 1'b1;
    cmd_data  = {op, idx, 3'b000, cfg};
    waits     = 0;
    do begin
      ok = cmd_ready;
      tick();
      waits++;
    end while (!ok && waits < 200);
    cmd_valid = 1'b0;
    cmd_data  = 16'h0000;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: command not accepted, ready=%b", cmd_ready);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bidir_oe !== ALL0) begin errors++; $display("FAIL reset_oe: got %h want %h", bidir_oe, ALL0); end
    checks++; if (bidir_ie !== ALL1) begin errors++; $display("FAIL reset_ie: got %h want %h", bidir_ie, ALL1); end
    checks++; if ((bidir_cs | bidir_sl | bidir_pu | bidir_pd) !== ALL0) begin errors++; $display("FAIL reset_misc: cs|sl|pu|pd got %h want 0", bidir_cs | bidir_sl | bidir_pu | bidir_pd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (commit_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", commit_cnt); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
  endtask

  // cfg 10010 decodes as oe=1, pu=1
  task automatic test_write_commit();
    logic [N-1:0] p3;
    p3 = ALL0;
    p3[3] = 1'b1;
    send(2'b01, 6'd3, 5'b10010);
    checks++; if (bidir_oe !== ALL0) begin errors++; $display("FAIL write_no_live: oe got %h want %h", bidir_oe, ALL0); end
    send(2'b10, 6'd0, 5'b00000);
    checks++; if (bidir_oe !== p3) begin errors++; $display("FAIL commit_oe: got %h want %h", bidir_oe, p3); end
    checks++; if (bidir_pu !== p3) begin errors++; $display("FAIL commit_pu: got %h want %h", bidir_pu, p3); end
    checks++; if ((bidir_sl | bidir_cs | bidir_pd) !== ALL0) begin errors++; $display("FAIL commit_other: got %h want 0", bidir_sl | bidir_cs | bidir_pd); end
    checks++; if (bidir_ie !== ~p3) begin errors++; $display("FAIL commit_ie: got %h want %h", bidir_ie, ~p3); end
    checks++; if (commit_cnt !== 8'd1) begin errors++; $display("FAIL commit_cnt1: got %0d want 1", commit_cnt); end
  endtask

  task automatic test_errors();
    logic [N-1:0] p3, p41;
    p3 = ALL0;  p3[3] = 1'b1;
    p41 = ALL0; p41[41] = 1'b1;
    send(2'b01, 6'd42, 5'b10000);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_idx: got %b want 1", err); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr: got %b want 0", err); end
    send(2'b01, 6'd5, 5'b10011);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_pupd: got %b want 1", err); end
    send(2'b01, 6'd41, 5'b00100);
    send(2'b10, 6'd0, 5'b00000);
    checks++; if (bidir_oe !== p3) begin errors++; $display("FAIL err_oe_kept: got %h want %h", bidir_oe, p3); end
    checks++; if (bidir_pd !== ALL0) begin errors++; $display("FAIL err_pd_kept: got %h want 0", bidir_pd); end
    checks++; if (bidir_sl !== p41) begin errors++; $display("FAIL last_pad_sl: got %h want %h", bidir_sl, p41); end
    checks++; if (commit_cnt !== 8'd2) begin errors++; $display("FAIL commit_cnt2: got %0d want 2", commit_cnt); end
    // set and clear in the same cycle: set wins
    err_clr = 1'b1;
    send(2'b01, 6'd63, 5'b00000);
    err_clr = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b want 1", err); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr2: got %b want 0", err); end
  endtask

  task automatic test_defaults();
    int waits;
    for (int i = 0; i < N; i++) send(2'b01, 6'(i), 5'b10000);
    send(2'b10, 6'd0, 5'b00000);
    checks++; if (bidir_oe !== ALL1) begin errors++; $display("FAIL all_oe: got %h want %h", bidir_oe, ALL1); end
    checks++; if (bidir_sl !== ALL0) begin errors++; $display("FAIL all_sl: got %h want 0", bidir_sl); end
    send(2'b11, 6'd0, 5'b00000);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL sweep_ready: got %b want 0", cmd_ready); end
    // COMMIT presented during the sweep must wait for IDLE
    cmd_valid = 1'b1;
    cmd_data  = {2'b10, 6'd0, 8'h00};
    waits = 0;
    while (!cmd_ready && waits < 100) begin
      if (waits == 20) begin
        checks++; if (bidir_oe !== ALL1) begin errors++; $display("FAIL sweep_live_kept: got %h want %h", bidir_oe, ALL1); end
      end
      tick();
      waits++;
    end
    checks++; if (waits !== N - 1) begin errors++; $display("FAIL sweep_len: got %0d want %0d", waits, N - 1); end
    checks++; if (commit_cnt !== 8'd3) begin errors++; $display("FAIL held_cmd: cnt got %0d want 3", commit_cnt); end
    tick();
    cmd_valid = 1'b0;
    cmd_data  = 16'h0000;
    checks++; if (bidir_oe !== ALL0) begin errors++; $display("FAIL defaults_oe: got %h want 0", bidir_oe); end
    checks++; if (bidir_ie !== ALL1) begin errors++; $display("FAIL defaults_ie: got %h want %h", bidir_ie, ALL1); end
    checks++; if (commit_cnt !== 8'd4) begin errors++; $display("FAIL commit_cnt4: got %0d want 4", commit_cnt); end
  endtask

  task automatic test_reset_in_sweep();
    send(2'b01, 6'd0, 5'b11000);
    send(2'b10, 6'd0, 5'b00000);
    send(2'b01, 6'd50, 5'b00000);
    send(2'b11, 6'd0, 5'b00000);
    for (int i = 0; i < 9; i++) tick();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_sweep_ready: got %b want 0", cmd_ready); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_sweep_ready: got %b want 1", cmd_ready); end
    checks++; if ((bidir_oe | bidir_cs) !== ALL0) begin errors++; $display("FAIL rst_sweep_live: got %h want 0", bidir_oe | bidir_cs); end
    checks++; if (bidir_ie !== ALL1) begin errors++; $display("FAIL rst_sweep_ie: got %h want %h", bidir_ie, ALL1); end
    checks++; if ({err, commit_cnt} !== 9'd0) begin errors++; $display("FAIL rst_sweep_regs: err=%b cnt=%0d want 0/0", err, commit_cnt); end
  endtask

  task automatic test_back_to_back();
    int not_ready;
    not_ready = 0;
    cmd_valid = 1'b1;
    cmd_data  = {2'b10, 14'd0};
    for (int i = 1; i <= 257; i++) begin
      if (cmd_ready !== 1'b1) not_ready++;
      tick();
      if (i == 255) begin
        checks++; if (commit_cnt !== 8'd255) begin errors++; $display("FAIL cnt255: got %0d want 255", commit_cnt); end
      end
      if (i == 256) begin
        checks++; if (commit_cnt !== 8'd0) begin errors++; $display("FAIL cnt_wrap: got %0d want 0", commit_cnt); end
      end
    end
    cmd_valid = 1'b0;
    cmd_data  = 16'h0000;
    checks++; if (commit_cnt !== 8'd1) begin errors++; $display("FAIL cnt257: got %0d want 1", commit_cnt); end
    checks++; if (not_ready !== 0) begin errors++; $display("FAIL b2b_ready: low %0d cycles want 0", not_ready); end
  endtask

  initial begin
    #2;
    test_reset();
    test_write_commit();
    test_errors();
    test_defaults();
    test_reset_in_sweep();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pad_cfg_ctrl
`default_nettype wire
